// File: rtl/mul12_pkg.sv
// Shared types and constants for the quotient/remainder to numerator composer.
// Range checking in mul12_compose is enabled by defining MUL12_RANGE_CHECK_EN.
package mul12_pkg;

   localparam int unsigned DIVISOR = 12;
   localparam int unsigned REM_MAX = 11;
   localparam int unsigned ACC_W   = 7;
   localparam int unsigned Q_W     = 3;
   localparam int unsigned R_W     = 4;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADD8 = 3'd1,
      ADD4 = 3'd2,
      ADDR = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/mul12_compose.sv
// Multi-cycle numerator = quotient*12 + remainder using shift-and-add (8q + 4q + r).
// Define MUL12_RANGE_CHECK_EN to flag illegal remainders and truncated results on err.
module mul12_compose
   import mul12_pkg::*;
#(
   parameter int unsigned NUM_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [Q_W-1:0]   quotient,
   input  logic [R_W-1:0]   remainder,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NUM_W-1:0] numerator,
   output logic             err
);

   state_t             r_state;
   state_t             w_next;
   logic               r_in_ready;
   logic               r_out_valid;
   logic [Q_W-1:0]     r_q;
   logic [R_W-1:0]     r_rem;
   logic [ACC_W-1:0]   r_acc;
   logic [NUM_W-1:0]   r_num;
   logic               w_accept;

   assign w_accept  = in_valid & r_in_ready;
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign numerator = r_num;

   // State register; handshake flags are registered from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_in_ready  <= (w_next == IDLE);
         r_out_valid <= (w_next == DONE);
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (in_valid) w_next = ADD8;
         ADD8:    w_next = ADD4;
         ADD4:    w_next = ADDR;
         ADDR:    w_next = DONE;
         DONE:    if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Accumulator: 8q is loaded at accept, then 4q and r are added.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q   <= '0;
         r_rem <= '0;
         r_acc <= '0;
         r_num <= '0;
      end else begin
         unique case (r_state)
            IDLE: if (w_accept) begin
               r_q   <= quotient;
               r_rem <= remainder;
               r_acc <= ACC_W'({quotient, 3'b000});
            end
            ADD8:    r_acc <= r_acc + ACC_W'({r_q, 2'b00});
            ADD4:    r_acc <= r_acc + ACC_W'(r_rem);
            ADDR:    r_num <= NUM_W'(r_acc);
            default: ;
         endcase
      end
   end

`ifdef MUL12_RANGE_CHECK_EN
   logic r_err;
   logic w_rem_bad;
   logic w_ovf;

   assign w_rem_bad = (r_rem > R_W'(REM_MAX));
   assign w_ovf     = ((r_acc >> NUM_W) != ACC_W'(0));
   assign err       = r_err;

   // Fault is captured with the result and cleared when it is consumed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err <= 1'b0;
      end else if (r_state == ADDR) begin
         r_err <= w_rem_bad | w_ovf;
      end else if ((r_state == DONE) && out_ready) begin
         r_err <= 1'b0;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule
